// File: rtl/priority_encoder_rr_if.sv
// Request/index handshake bundle for priority_encoder_rr.
// The slave side is the encoder; the master side is the request source and index consumer.
interface priority_encoder_rr_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] a;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    logic         last;

    modport master (
        output a, a_valid, y_ready,
        input  a_ready, y, y_valid, last
    );

    modport slave (
        input  a, a_valid, y_ready,
        output a_ready, y, y_valid, last
    );
endinterface

// File: rtl/priority_encoder_rr.sv
// Latches an N-bit request vector and emits the index of every set bit, one per
// output handshake, highest-first (MODE=0) or round-robin from a rotating pointer (MODE=1).
module priority_encoder_rr #(
    parameter int N    = 8,
    parameter int MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    priority_encoder_rr_if.slave bus,
    output logic                 zero_seen,
    output logic                 busy
);
    localparam int W = $clog2(N);

    logic [N-1:0] p_q, p_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         zero_seen_q, zero_seen_d;

    logic [W-1:0] sel_hi, sel_lo, sel_ge, sel_rr, sel;
    logic         found_ge;
    logic         pend, one_left, accept, out_hs;

    // Ascending scan leaves the highest set index in sel_hi; the descending scan
    // leaves the lowest set index overall and the lowest one at or above ptr.
    always_comb begin
        sel_hi   = '0;
        sel_lo   = '0;
        sel_ge   = '0;
        found_ge = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (p_q[i]) sel_hi = W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (p_q[i]) begin
                sel_lo = W'(i);
                if (i >= int'(ptr_q)) begin
                    sel_ge   = W'(i);
                    found_ge = 1'b1;
                end
            end
        end
        sel_rr = found_ge ? sel_ge : sel_lo;
        sel    = (MODE == 1) ? sel_rr : sel_hi;
    end

    assign pend     = |p_q;
    assign one_left = pend && ((p_q & (p_q - N'(1))) == '0);
    assign accept   = enable && !pend && bus.a_valid;
    assign out_hs   = enable && pend && bus.y_ready;

    assign bus.a_ready = enable && !pend;
    assign bus.y_valid = enable && pend;
    assign bus.y       = sel;
    assign bus.last    = enable && pend && one_left;
    assign busy        = pend;
    assign zero_seen   = zero_seen_q;

    // Accept and output handshake never coincide: one needs p empty, the other non-empty.
    always_comb begin
        p_d         = p_q;
        ptr_d       = ptr_q;
        zero_seen_d = zero_seen_q;
        if (enable) begin
            zero_seen_d = accept && (bus.a == '0);
            if (accept) begin
                p_d = bus.a;
            end else if (out_hs) begin
                p_d[sel] = 1'b0;
                if (MODE == 1) begin
                    ptr_d = (int'(sel) == N - 1) ? '0 : sel + W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q         <= '0;
            ptr_q       <= '0;
            zero_seen_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            ptr_q       <= ptr_d;
            zero_seen_q <= zero_seen_d;
        end
    end
endmodule

// File: tb/tb_priority_encoder_rr.sv
// Drives a fixed-priority and a round-robin encoder with identical stimulus and
// checks both every cycle against a pending-set model, plus directed index sequences.
module tb_priority_encoder_rr;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [N-1:0] a;
    logic         a_valid;
    logic         y_ready;
    logic         zs0, zs1, busy0, busy1;

    priority_encoder_rr_if #(.N(N)) if0 ();
    priority_encoder_rr_if #(.N(N)) if1 ();

    assign if0.a       = a;
    assign if0.a_valid = a_valid;
    assign if0.y_ready = y_ready;
    assign if1.a       = a;
    assign if1.a_valid = a_valid;
    assign if1.y_ready = y_ready;

    priority_encoder_rr #(.N(N), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .bus(if0.slave),
        .zero_seen(zs0), .busy(busy0)
    );
    priority_encoder_rr #(.N(N), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .bus(if1.slave),
        .zero_seen(zs1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Model: the set of pending request indices, the round-robin pointer and the zero flag.
    logic [N-1:0] m_p [2];
    int           m_ptr [2];
    bit           m_zs [2];
    int           n_assert = 0;
    int           n_fail   = 0;
    int           log0[$];
    int           log1[$];

    function automatic int ref_sel(input int k);
        if (m_p[k] == '0) return 0;
        if (k == 0) begin
            for (int i = N - 1; i >= 0; i--) if (m_p[k][i]) return i;
        end else begin
            for (int s = 0; s < N; s++) begin
                int idx;
                idx = (m_ptr[k] + s) % N;
                if (m_p[k][idx]) return idx;
            end
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_p[k]   = '0;
            m_ptr[k] = 0;
            m_zs[k]  = 1'b0;
        end
    endtask

    // One clock: check all outputs at the falling edge, then advance the model at the rising edge.
    task automatic cyc();
        logic ar[2], yv[2], la[2], bz[2], zs[2];
        logic [31:0] yo[2];
        @(negedge clk);
        ar[0] = if0.a_ready; yv[0] = if0.y_valid; yo[0] = 32'(if0.y); la[0] = if0.last;
        bz[0] = busy0;       zs[0] = zs0;
        ar[1] = if1.a_ready; yv[1] = if1.y_valid; yo[1] = 32'(if1.y); la[1] = if1.last;
        bz[1] = busy1;       zs[1] = zs1;
        for (int k = 0; k < 2; k++) begin
            logic ev;
            ev = enable && (m_p[k] != '0);
            chk($sformatf("a_ready[m%0d]", k), 32'(ar[k]), 32'(enable && (m_p[k] == '0)));
            chk($sformatf("y_valid[m%0d]", k), 32'(yv[k]), 32'(ev));
            chk($sformatf("y[m%0d]", k), yo[k], 32'(ref_sel(k)));
            chk($sformatf("last[m%0d]", k), 32'(la[k]), 32'(ev && ($countones(m_p[k]) == 1)));
            chk($sformatf("busy[m%0d]", k), 32'(bz[k]), 32'(m_p[k] != '0));
            chk($sformatf("zero_seen[m%0d]", k), 32'(zs[k]), 32'(m_zs[k]));
        end
        if (yv[0] && y_ready) log0.push_back(int'(yo[0]));
        if (yv[1] && y_ready) log1.push_back(int'(yo[1]));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (enable) begin
                bit acc;
                acc     = (m_p[k] == '0) && a_valid;
                m_zs[k] = acc && (a == '0);
                if (acc) begin
                    m_p[k] = a;
                end else if ((m_p[k] != '0) && y_ready) begin
                    int e;
                    e = ref_sel(k);
                    m_p[k][e] = 1'b0;
                    if (k == 1) m_ptr[k] = (e + 1) % N;
                end
            end
        end
        #1;
    endtask

    task automatic send(input logic [N-1:0] v);
        bit done;
        a       = v;
        a_valid = 1'b1;
        done    = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            bit acc;
            acc = enable && (m_p[0] == '0);
            cyc();
            if (acc) done = 1'b1;
        end
        a_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 64 && ((m_p[0] != '0) || (m_p[1] != '0)); t++) cyc();
    endtask

    task automatic expect_log(input int k, input string tag, input int n,
                              input int e0, input int e1, input int e2, input int e3);
        int got[$];
        int e[4];
        e = '{e0, e1, e2, e3};
        got = (k == 0) ? log0 : log1;
        chk({tag, "_count"}, 32'(got.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(e[i]));
        end
        if (k == 0) log0.delete(); else log1.delete();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; a = '0; a_valid = 1'b0; y_ready = 1'b1;
        model_reset();
        cyc();
        cyc();
        rst = 1'b0;

        // One-hot sweep: each vector yields its own index, flagged last.
        for (int i = 0; i < N; i++) begin
            send(N'(1) << i);
            drain();
            expect_log(0, "sweep_m0", 1, i, 0, 0, 0);
            expect_log(1, "sweep_m1", 1, i, 0, 0, 0);
        end

        send(8'b1010_0101);
        drain();
        expect_log(0, "multi_m0", 4, 7, 5, 2, 0);
        expect_log(1, "multi_m1", 4, 0, 2, 5, 7);

        // Asynchronous reset in the middle of a drain.
        send(8'b1010_0000);
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("rst_y_valid", 32'(if0.y_valid), 32'd0);
        chk("rst_y", 32'(if0.y), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_a_ready", 32'(if0.a_ready), 32'd1);
        chk("rst_y_valid_m1", 32'(if1.y_valid), 32'd0);
        chk("rst_busy_m1", 32'(busy1), 32'd0);
        model_reset();
        cyc();
        rst = 1'b0;
        expect_log(0, "prerst_m0", 1, 7, 0, 0, 0);
        expect_log(1, "prerst_m1", 1, 5, 0, 0, 0);
        send(8'b1000_0001);
        drain();
        expect_log(0, "postrst_m0", 2, 7, 0, 0, 0);
        expect_log(1, "postrst_m1", 2, 0, 7, 0, 0);

        // Round-robin wrap, then a vector that exposes the pointer left behind.
        send(8'b0000_0101);
        drain();
        expect_log(1, "wrap1_m1", 2, 0, 2, 0, 0);
        expect_log(0, "wrap1_m0", 2, 2, 0, 0, 0);
        send(8'b1000_0011);
        drain();
        expect_log(1, "wrap2_m1", 3, 7, 0, 1, 0);
        expect_log(0, "wrap2_m0", 3, 7, 1, 0, 0);
        send(8'b0000_0110);
        drain();
        expect_log(1, "ptr2_m1", 2, 2, 1, 0, 0);
        expect_log(0, "ptr2_m0", 2, 2, 1, 0, 0);

        // Backpressure, then freeze with enable low.
        y_ready = 1'b0;
        send(8'b0001_0010);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_y", 32'(if0.y), 32'd4);
            chk("bp_y_valid", 32'(if0.y_valid), 32'd1);
        end
        enable = 1'b0;
        cyc();
        cyc();
        enable  = 1'b1;
        y_ready = 1'b1;
        drain();
        expect_log(0, "bp_m0", 2, 4, 1, 0, 0);
        expect_log(1, "bp_m1", 2, 4, 1, 0, 0);

        // Zero vector pulse, and the flag held while disabled.
        send('0);
        chk("zs_pulse", 32'(zs0), 32'd1);
        chk("zs_busy", 32'(busy0), 32'd0);
        cyc();
        chk("zs_clear", 32'(zs0), 32'd0);
        send('0);
        enable = 1'b0;
        cyc();
        cyc();
        chk("zs_frozen", 32'(zs1), 32'd1);
        enable = 1'b1;
        cyc();

        // A vector offered during a drain waits for the block to go idle.
        send(8'b0000_0011);
        send(8'b1000_0000);
        drain();
        expect_log(0, "held_m0", 3, 1, 0, 7, 0);
        expect_log(1, "held_m1", 3, 0, 1, 7, 0);

        for (int i = 0; i < 400; i++) begin
            a       = ($urandom_range(0, 1) == 0) ? N'($urandom) : N'($urandom & $urandom);
            a_valid = $urandom_range(0, 1) == 1;
            y_ready = $urandom_range(0, 3) != 0;
            enable  = $urandom_range(0, 7) != 0;
            cyc();
        end
        a_valid = 1'b0;
        enable  = 1'b1;
        y_ready = 1'b1;
        drain();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
